fml_mem_txn_tracker: RTL and testbench
======================================

Name: fml_mem_txn_tracker

Overview:
- Parametrised successor to the fixed four-transaction memory-port bundle used by the formal checkers.
- Observes the COP memory bus over a request/grant plus in-order response protocol.
- Collects every transaction issued by one instruction into NUM_TXN slots.
- On retire, publishes a stable per-instruction snapshot with a one-cycle vtx_valid pulse, so checker modules get per-transaction cen/wen/addr/wdata/rdata/ben/error for any channel count.

Parameters:
- NUM_TXN, 4: number of transaction slots per instruction; must be >= 1.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte-enable width is DATA_W/8.
- CNT_W, $clog2(NUM_TXN+1): width of the slot and outstanding counters.

Ports:
- vtx_clk, in, 1: single clock; all state updates on rising edge.
- vtx_resetn, in, 1: asynchronous, active-low reset.
- mem_cen, in, 1: request valid.
- mem_gnt, in, 1: request grant; a request is accepted when mem_cen && mem_gnt.
- mem_wen, in, 1: write request.
- mem_addr, in, ADDR_W: request address.
- mem_wdata, in, DATA_W: write data.
- mem_ben, in, DATA_W/8: byte enables.
- mem_rvalid, in, 1: response valid; responses return in request order.
- mem_rdata, in, DATA_W: response data.
- mem_error, in, 1: response bus error.
- instr_retire, in, 1: pulse marking the end of the current instruction.
- instr_flush, in, 1: current instruction killed; discard its transactions.
- vtx_valid, out, 1: one-cycle pulse; the snapshot outputs are valid.
- vtx_txn_count, out, CNT_W: number of slots filled in the snapshot.
- vtx_mem_cen, out, NUM_TXN: per-slot used bit.
- vtx_mem_wen, out, NUM_TXN: per-slot write flag.
- vtx_mem_addr, out, NUM_TXN*ADDR_W: slot i occupies bits [i*ADDR_W +: ADDR_W].
- vtx_mem_wdata, out, NUM_TXN*DATA_W: slot-packed as for vtx_mem_addr.
- vtx_mem_rdata, out, NUM_TXN*DATA_W: slot-packed.
- vtx_mem_ben, out, NUM_TXN*DATA_W/8: slot-packed.
- vtx_mem_error, out, NUM_TXN: per-slot response error.
- vtx_overflow, out, 1: snapshot instruction issued more than NUM_TXN requests.
- vtx_proto_err, out, 1: sticky protocol violation flag.

Behaviour:
- Reset: all outputs 0, including snapshot fields and vtx_proto_err. Working bank cleared; wr_ptr = rsp_ptr = 0; outstanding = 0; state COLLECT. Reset mid-DRAIN aborts with no publish.
- Two banks:
  - Working bank is written by the bus.
  - Snapshot bank drives the outputs and holds its value until the next publish.
- Request accept, wr_ptr < NUM_TXN:
  - Slot[wr_ptr] captures cen=1, wen, addr, wdata, ben.
  - wr_ptr++, outstanding++.
- Request accept, wr_ptr == NUM_TXN:
  - Nothing is stored; the working overflow flag is set.
  - outstanding++, tracked through a separate drop counter.
- Response (mem_rvalid):
  - If rsp_ptr < wr_ptr: slot[rsp_ptr] captures rdata and error; rsp_ptr++.
  - Otherwise the response belongs to a dropped request: ignored.
  - outstanding-- in both cases.
  - With outstanding == 0: vtx_proto_err is set and no counter changes.
- Same-cycle accept and response: both apply; outstanding is unchanged.
- FSM, state COLLECT:
  - instr_retire with outstanding-after-this-cycle == 0: publish next edge.
  - instr_retire otherwise: go to DRAIN.
  - A request accepted in the retire cycle belongs to the retiring instruction.
- FSM, state DRAIN:
  - Waits for outstanding to reach 0, then publishes and returns to COLLECT.
  - Any accepted request, or instr_retire, while in DRAIN sets vtx_proto_err; the request is still recorded.
- Publish:
  - Snapshot <= working bank; vtx_txn_count <= wr_ptr; vtx_overflow <= working overflow.
  - vtx_valid = 1 for exactly one cycle; latency is 1 cycle after the last response, or after retire if nothing is outstanding.
  - Working bank cleared the same edge.
- instr_flush in any state:
  - Clears the working bank, pointers and overflow; returns to COLLECT.
  - No vtx_valid.
  - outstanding is preserved so that late responses are absorbed without a proto_err: after a flush, responses only decrement outstanding.
  - Flush has priority over a same-cycle retire.
- Counters saturate: outstanding never wraps; an attempted overflow past the maximum sets vtx_proto_err.

Decomposition:
- Shared package fml_trk_pkg holds:
  - State enum: COLLECT, DRAIN.
  - Default width constants.
  - The slot-packing index function, also used by the checker modules for unpacking.
- Sub-module fml_txn_slot: one working-bank slot with request and response capture and clear. The top instantiates it NUM_TXN times via generate.

Test Plan:
1. Single read: accept addr 0x100, ben 0xF; response rdata 0xDEADBEEF two cycles later; retire with the response → vtx_valid 1 cycle later; count 1; slot0 cen=1, wen=0, rdata 0xDEADBEEF.
2. Retire with 3 outstanding requests (addr 0x0/0x4/0x8), responses arrive 5 cycles later → vtx_valid only after the 3rd response; count 3; slot ordering matches issue order.
3. NUM_TXN=4 with 6 requests and 6 responses → count 4; vtx_overflow=1; slots 0-3 hold the first four; no proto_err.
4. Request accepted with a response in the same cycle while 1 is outstanding → outstanding stays 1; rdata lands in the correct slot.
5. Flush with 2 outstanding, then 2 responses, then a new instruction with 1 write (wdata 0x12345678) and retire → no publish for the flushed instruction; next snapshot count 1, wen=1; proto_err=0.
6. Response with nothing outstanding, and a separate vtx_resetn drop mid-DRAIN → vtx_proto_err=1 until reset; after reset all outputs are 0 and no vtx_valid occurs.

Source files
------------

// File: rtl/fml_trk_pkg.sv
// Shared types and helpers for the memory transaction tracker and the checker
// modules that unpack its slot-packed snapshot buses.
package fml_trk_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      DRAIN   = 1'b1
   } trk_state_e;

   localparam int DEF_NUM_TXN = 4;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;

   // LSB of slot 'slot' inside a bus packing fields of 'width' bits per slot.
   function automatic int slot_lsb(input int slot, input int width);
      return slot * width;
   endfunction

endpackage

// File: rtl/fml_txn_slot.sv
// One working-bank slot: captures a request and later its response.
// The cap_* outputs already include this cycle's captures so a publish sees them.
module fml_txn_slot
   import fml_trk_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clr_i,
   input  logic                req_we_i,
   input  logic                req_wen_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [DATA_W-1:0]   req_wdata_i,
   input  logic [DATA_W/8-1:0] req_ben_i,
   input  logic                rsp_we_i,
   input  logic [DATA_W-1:0]   rsp_rdata_i,
   input  logic                rsp_error_i,
   output logic                cap_cen_o,
   output logic                cap_wen_o,
   output logic [ADDR_W-1:0]   cap_addr_o,
   output logic [DATA_W-1:0]   cap_wdata_o,
   output logic [DATA_W/8-1:0] cap_ben_o,
   output logic [DATA_W-1:0]   cap_rdata_o,
   output logic                cap_error_o
);

   logic                cen_q;
   logic                wen_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] ben_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                error_q;

   always_comb begin
      cap_cen_o   = cen_q | req_we_i;
      cap_wen_o   = req_we_i ? req_wen_i   : wen_q;
      cap_addr_o  = req_we_i ? req_addr_i  : addr_q;
      cap_wdata_o = req_we_i ? req_wdata_i : wdata_q;
      cap_ben_o   = req_we_i ? req_ben_i   : ben_q;
      cap_rdata_o = rsp_we_i ? rsp_rdata_i : rdata_q;
      cap_error_o = rsp_we_i ? rsp_error_i : error_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cen_q   <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ben_q   <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else if (clr_i) begin
         cen_q   <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ben_q   <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         cen_q   <= cap_cen_o;
         wen_q   <= cap_wen_o;
         addr_q  <= cap_addr_o;
         wdata_q <= cap_wdata_o;
         ben_q   <= cap_ben_o;
         rdata_q <= cap_rdata_o;
         error_q <= cap_error_o;
      end
   end

endmodule

// File: rtl/fml_mem_txn_tracker.sv
// Collects the memory transactions of one instruction into NUM_TXN slots and
// publishes a stable snapshot with a one-cycle vtx_valid pulse on retire.
module fml_mem_txn_tracker
   import fml_trk_pkg::*;
#(
   parameter int NUM_TXN = DEF_NUM_TXN,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CNT_W   = $clog2(NUM_TXN + 1)
) (
   input  logic                          vtx_clk,
   input  logic                          vtx_resetn,
   input  logic                          mem_cen,
   input  logic                          mem_gnt,
   input  logic                          mem_wen,
   input  logic [ADDR_W-1:0]             mem_addr,
   input  logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W/8-1:0]           mem_ben,
   input  logic                          mem_rvalid,
   input  logic [DATA_W-1:0]             mem_rdata,
   input  logic                          mem_error,
   input  logic                          instr_retire,
   input  logic                          instr_flush,
   output logic                          vtx_valid,
   output logic [CNT_W-1:0]              vtx_txn_count,
   output logic [NUM_TXN-1:0]            vtx_mem_cen,
   output logic [NUM_TXN-1:0]            vtx_mem_wen,
   output logic [NUM_TXN*ADDR_W-1:0]     vtx_mem_addr,
   output logic [NUM_TXN*DATA_W-1:0]     vtx_mem_wdata,
   output logic [NUM_TXN*DATA_W-1:0]     vtx_mem_rdata,
   output logic [NUM_TXN*DATA_W/8-1:0]   vtx_mem_ben,
   output logic [NUM_TXN-1:0]            vtx_mem_error,
   output logic                          vtx_overflow,
   output logic                          vtx_proto_err
);

   localparam int              BEN_W   = DATA_W / 8;
   localparam logic [CNT_W-1:0] SLOTS   = CNT_W'(NUM_TXN);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   trk_state_e       state_q, state_d;
   logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_cap;
   logic [CNT_W-1:0] rsp_ptr_q, rsp_ptr_d;
   logic [CNT_W-1:0] out_q, out_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [CNT_W-1:0] orphan_q, orphan_d;
   logic             ovf_q, ovf_d, ovf_cap;
   logic             err_q, err_d;

   logic acc, acc_slot, acc_drop;
   logic rsp_ok, rsp_orphan, rsp_slot, rsp_drop;
   logic sat_err, publish, slot_clr;

   logic [NUM_TXN-1:0]          cap_cen, cap_wen, cap_err;
   logic [NUM_TXN*ADDR_W-1:0]   cap_addr;
   logic [NUM_TXN*DATA_W-1:0]   cap_wdata, cap_rdata;
   logic [NUM_TXN*BEN_W-1:0]    cap_ben;

   logic                        valid_q;
   logic [CNT_W-1:0]            cnt_q;
   logic                        snap_ovf_q;
   logic [NUM_TXN-1:0]          snap_cen_q, snap_wen_q, snap_err_q;
   logic [NUM_TXN*ADDR_W-1:0]   snap_addr_q;
   logic [NUM_TXN*DATA_W-1:0]   snap_wdata_q, snap_rdata_q;
   logic [NUM_TXN*BEN_W-1:0]    snap_ben_q;

   always_comb begin
      acc        = mem_cen && mem_gnt;
      acc_slot   = acc && (wr_ptr_q < SLOTS);
      acc_drop   = acc && !acc_slot;
      rsp_ok     = mem_rvalid && (out_q != '0);
      // Responses drain flushed requests first, then fill slots in order, then drops.
      rsp_orphan = rsp_ok && (orphan_q != '0);
      rsp_slot   = rsp_ok && !rsp_orphan && (rsp_ptr_q < wr_ptr_q);
      rsp_drop   = rsp_ok && !rsp_orphan && !rsp_slot;

      sat_err = 1'b0;
      out_d   = out_q;
      if (acc && !rsp_ok) begin
         if (out_q == CNT_MAX) sat_err = 1'b1;
         else                  out_d   = out_q + CNT_ONE;
      end else if (!acc && rsp_ok) begin
         out_d = out_q - CNT_ONE;
      end

      drop_d = drop_q;
      if (acc_drop && !rsp_drop) begin
         if (drop_q == CNT_MAX) sat_err = 1'b1;
         else                   drop_d  = drop_q + CNT_ONE;
      end else if (!acc_drop && rsp_drop && (drop_q != '0)) begin
         drop_d = drop_q - CNT_ONE;
      end

      wr_ptr_cap = wr_ptr_q + CNT_W'(acc_slot);
      ovf_cap    = ovf_q | acc_drop;
      wr_ptr_d   = wr_ptr_cap;
      rsp_ptr_d  = rsp_ptr_q + CNT_W'(rsp_slot);
      orphan_d   = orphan_q - CNT_W'(rsp_orphan);
      ovf_d      = ovf_cap;

      err_d = err_q | (mem_rvalid && (out_q == '0)) | sat_err
            | ((state_q == DRAIN) && (acc || instr_retire));

      state_d = state_q;
      publish = 1'b0;
      if (instr_flush) begin
         state_d   = COLLECT;
         wr_ptr_d  = '0;
         rsp_ptr_d = '0;
         ovf_d     = 1'b0;
         drop_d    = '0;
         orphan_d  = out_d;
      end else begin
         case (state_q)
            COLLECT: begin
               if (instr_retire) begin
                  if (out_d == '0) publish = 1'b1;
                  else             state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (out_d == '0) begin
                  publish = 1'b1;
                  state_d = COLLECT;
               end
            end
            default: state_d = COLLECT;
         endcase
         if (publish) begin
            wr_ptr_d  = '0;
            rsp_ptr_d = '0;
            ovf_d     = 1'b0;
            drop_d    = '0;
         end
      end
      slot_clr = publish | instr_flush;
   end

   always_ff @(posedge vtx_clk or negedge vtx_resetn) begin
      if (!vtx_resetn) begin
         state_q   <= COLLECT;
         wr_ptr_q  <= '0;
         rsp_ptr_q <= '0;
         out_q     <= '0;
         drop_q    <= '0;
         orphan_q  <= '0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rsp_ptr_q <= rsp_ptr_d;
         out_q     <= out_d;
         drop_q    <= drop_d;
         orphan_q  <= orphan_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_TXN; gi++) begin : g_slot
         localparam int A_LSB = slot_lsb(gi, ADDR_W);
         localparam int D_LSB = slot_lsb(gi, DATA_W);
         localparam int B_LSB = slot_lsb(gi, BEN_W);
         logic req_we, rsp_we;

         assign req_we = acc_slot && (wr_ptr_q == CNT_W'(gi));
         assign rsp_we = rsp_slot && (rsp_ptr_q == CNT_W'(gi));

         fml_txn_slot #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
         ) u_slot (
            .clk_i       (vtx_clk),
            .rst_ni      (vtx_resetn),
            .clr_i       (slot_clr),
            .req_we_i    (req_we),
            .req_wen_i   (mem_wen),
            .req_addr_i  (mem_addr),
            .req_wdata_i (mem_wdata),
            .req_ben_i   (mem_ben),
            .rsp_we_i    (rsp_we),
            .rsp_rdata_i (mem_rdata),
            .rsp_error_i (mem_error),
            .cap_cen_o   (cap_cen[gi]),
            .cap_wen_o   (cap_wen[gi]),
            .cap_addr_o  (cap_addr[A_LSB +: ADDR_W]),
            .cap_wdata_o (cap_wdata[D_LSB +: DATA_W]),
            .cap_ben_o   (cap_ben[B_LSB +: BEN_W]),
            .cap_rdata_o (cap_rdata[D_LSB +: DATA_W]),
            .cap_error_o (cap_err[gi])
         );
      end
   endgenerate

   // Snapshot bank: only changes on publish, so checkers may sample it any time.
   always_ff @(posedge vtx_clk or negedge vtx_resetn) begin
      if (!vtx_resetn) begin
         valid_q      <= 1'b0;
         cnt_q        <= '0;
         snap_ovf_q   <= 1'b0;
         snap_cen_q   <= '0;
         snap_wen_q   <= '0;
         snap_err_q   <= '0;
         snap_addr_q  <= '0;
         snap_wdata_q <= '0;
         snap_rdata_q <= '0;
         snap_ben_q   <= '0;
      end else begin
         valid_q <= publish;
         if (publish) begin
            cnt_q        <= wr_ptr_cap;
            snap_ovf_q   <= ovf_cap;
            snap_cen_q   <= cap_cen;
            snap_wen_q   <= cap_wen;
            snap_err_q   <= cap_err;
            snap_addr_q  <= cap_addr;
            snap_wdata_q <= cap_wdata;
            snap_rdata_q <= cap_rdata;
            snap_ben_q   <= cap_ben;
         end
      end
   end

   assign vtx_valid     = valid_q;
   assign vtx_txn_count = cnt_q;
   assign vtx_overflow  = snap_ovf_q;
   assign vtx_mem_cen   = snap_cen_q;
   assign vtx_mem_wen   = snap_wen_q;
   assign vtx_mem_error = snap_err_q;
   assign vtx_mem_addr  = snap_addr_q;
   assign vtx_mem_wdata = snap_wdata_q;
   assign vtx_mem_rdata = snap_rdata_q;
   assign vtx_mem_ben   = snap_ben_q;
   assign vtx_proto_err = err_q;

endmodule

// File: tb/tb_fml_mem_txn_tracker.sv
// Directed plus random bench for fml_mem_txn_tracker; expectations come from a
// queue-based model of instructions and in-order pending responses.
module tb_fml_mem_txn_tracker;

   localparam int NT = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int CW = $clog2(NT + 1);

   logic             vtx_clk = 1'b0;
   logic             vtx_resetn = 1'b1;
   logic             mem_cen = 1'b0, mem_gnt = 1'b0, mem_wen = 1'b0;
   logic [AW-1:0]    mem_addr = '0;
   logic [DW-1:0]    mem_wdata = '0;
   logic [BW-1:0]    mem_ben = '0;
   logic             mem_rvalid = 1'b0;
   logic [DW-1:0]    mem_rdata = '0;
   logic             mem_error = 1'b0;
   logic             instr_retire = 1'b0, instr_flush = 1'b0;

   logic             vtx_valid;
   logic [CW-1:0]    vtx_txn_count;
   logic [NT-1:0]    vtx_mem_cen, vtx_mem_wen, vtx_mem_error;
   logic [NT*AW-1:0] vtx_mem_addr;
   logic [NT*DW-1:0] vtx_mem_wdata, vtx_mem_rdata;
   logic [NT*BW-1:0] vtx_mem_ben;
   logic             vtx_overflow, vtx_proto_err;

   always #5 vtx_clk = ~vtx_clk;

   fml_mem_txn_tracker #(.NUM_TXN(NT), .ADDR_W(AW), .DATA_W(DW)) dut (
      .vtx_clk(vtx_clk), .vtx_resetn(vtx_resetn),
      .mem_cen(mem_cen), .mem_gnt(mem_gnt), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ben(mem_ben),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_error(mem_error),
      .instr_retire(instr_retire), .instr_flush(instr_flush),
      .vtx_valid(vtx_valid), .vtx_txn_count(vtx_txn_count),
      .vtx_mem_cen(vtx_mem_cen), .vtx_mem_wen(vtx_mem_wen),
      .vtx_mem_addr(vtx_mem_addr), .vtx_mem_wdata(vtx_mem_wdata),
      .vtx_mem_rdata(vtx_mem_rdata), .vtx_mem_ben(vtx_mem_ben),
      .vtx_mem_error(vtx_mem_error), .vtx_overflow(vtx_overflow),
      .vtx_proto_err(vtx_proto_err)
   );

   typedef struct {
      logic          wen;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      logic [BW-1:0] ben;
      logic          err;
   } req_t;

   req_t cur[$];   // every request of the current instruction, in issue order
   int   pend[$];  // outstanding responses: index into cur, -1 if flushed
   bit   m_drain;
   bit   m_err;

   logic             e_valid, e_ovf;
   logic [CW-1:0]    e_cnt;
   logic [NT-1:0]    e_cen, e_wen, e_errv;
   logic [NT*AW-1:0] e_addr;
   logic [NT*DW-1:0] e_wdata, e_rdata;
   logic [NT*BW-1:0] e_ben;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      cur.delete();
      pend.delete();
      m_drain = 1'b0;
      m_err   = 1'b0;
      e_valid = 1'b0; e_ovf = 1'b0; e_cnt = '0;
      e_cen = '0; e_wen = '0; e_errv = '0;
      e_addr = '0; e_wdata = '0; e_rdata = '0; e_ben = '0;
   endtask

   task automatic model_step();
      bit   acc, pre_drain;
      int   idx;
      req_t r;
      acc       = mem_cen && mem_gnt;
      pre_drain = m_drain;
      e_valid   = 1'b0;
      if (pre_drain && (acc || instr_retire)) m_err = 1'b1;
      if (mem_rvalid) begin
         if (pend.size() == 0) m_err = 1'b1;
         else begin
            idx = pend.pop_front();
            if (idx >= 0 && idx < NT) begin
               cur[idx].rdata = mem_rdata;
               cur[idx].err   = mem_error;
            end
         end
      end
      if (acc) begin
         r.wen = mem_wen; r.addr = mem_addr; r.wdata = mem_wdata;
         r.ben = mem_ben; r.rdata = '0; r.err = 1'b0;
         pend.push_back(cur.size());
         cur.push_back(r);
      end
      if (instr_flush) begin
         foreach (pend[k]) pend[k] = -1;
         cur.delete();
         m_drain = 1'b0;
      end else begin
         if (instr_retire) m_drain = 1'b1;
         if (m_drain && pend.size() == 0) begin
            e_valid = 1'b1;
            e_cnt   = CW'((cur.size() > NT) ? NT : cur.size());
            e_ovf   = (cur.size() > NT);
            for (int k = 0; k < NT; k++) begin
               if (k < cur.size()) begin
                  e_cen[k] = 1'b1; e_wen[k] = cur[k].wen; e_errv[k] = cur[k].err;
                  e_addr[k*AW +: AW]  = cur[k].addr;
                  e_wdata[k*DW +: DW] = cur[k].wdata;
                  e_rdata[k*DW +: DW] = cur[k].rdata;
                  e_ben[k*BW +: BW]   = cur[k].ben;
               end else begin
                  e_cen[k] = 1'b0; e_wen[k] = 1'b0; e_errv[k] = 1'b0;
                  e_addr[k*AW +: AW]  = '0;
                  e_wdata[k*DW +: DW] = '0;
                  e_rdata[k*DW +: DW] = '0;
                  e_ben[k*BW +: BW]   = '0;
               end
            end
            $display("txn publish @%0t: requests=%0d count=%0d overflow=%0d", $time,
                     cur.size(), e_cnt, e_ovf);
            cur.delete();
            m_drain = 1'b0;
         end
      end
   endtask

   task automatic check_outputs();
      chk("valid",     256'(vtx_valid),     256'(e_valid));
      chk("proto_err", 256'(vtx_proto_err), 256'(m_err));
      chk("count",     256'(vtx_txn_count), 256'(e_cnt));
      chk("overflow",  256'(vtx_overflow),  256'(e_ovf));
      chk("cen",       256'(vtx_mem_cen),   256'(e_cen));
      chk("wen",       256'(vtx_mem_wen),   256'(e_wen));
      chk("error",     256'(vtx_mem_error), 256'(e_errv));
      chk("addr",      256'(vtx_mem_addr),  256'(e_addr));
      chk("wdata",     256'(vtx_mem_wdata), 256'(e_wdata));
      chk("rdata",     256'(vtx_mem_rdata), 256'(e_rdata));
      chk("ben",       256'(vtx_mem_ben),   256'(e_ben));
   endtask

   task automatic idle_inputs();
      mem_cen = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      instr_retire = 1'b0; instr_flush = 1'b0;
   endtask

   task automatic cycle();
      model_step();
      @(posedge vtx_clk);
      #1;
      check_outputs();
      idle_inputs();
   endtask

   task automatic set_req(input logic wen, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [BW-1:0] ben);
      mem_cen = 1'b1; mem_gnt = 1'b1; mem_wen = wen;
      mem_addr = addr; mem_wdata = wdata; mem_ben = ben;
   endtask

   task automatic set_rsp(input logic [DW-1:0] rdata, input logic err);
      mem_rvalid = 1'b1; mem_rdata = rdata; mem_error = err;
   endtask

   task automatic do_reset();
      vtx_resetn = 1'b0;
      model_reset();
      #2;
      check_outputs();
      repeat (2) @(posedge vtx_clk);
      #1;
      check_outputs();
      vtx_resetn = 1'b1;
   endtask

   initial begin
      model_reset();
      #1;
      do_reset();

      // 1: single read, retire together with its response
      set_req(1'b0, 32'h100, 32'h0, 4'hF); cycle();
      cycle();
      set_rsp(32'hDEADBEEF, 1'b0); instr_retire = 1'b1; cycle();
      chk("t1_valid", 256'(vtx_valid), 256'(1));
      chk("t1_count", 256'(vtx_txn_count), 256'(1));
      chk("t1_rdata", 256'(vtx_mem_rdata[31:0]), 256'(32'hDEADBEEF));
      cycle();

      // 2: retire with three outstanding, responses arrive later
      for (int k = 0; k < 3; k++) begin
         set_req(1'b0, AW'(k * 4), DW'($urandom), 4'hF); cycle();
      end
      instr_retire = 1'b1; cycle();
      repeat (4) cycle();
      for (int k = 0; k < 3; k++) begin
         set_rsp(DW'($urandom), 1'b0); cycle();
      end
      chk("t2_count", 256'(vtx_txn_count), 256'(3));
      chk("t2_addr2", 256'(vtx_mem_addr[95:64]), 256'(8));

      // 3: six requests into four slots
      for (int k = 0; k < 6; k++) begin
         set_req(k[0], AW'(32'h200 + k * 4), DW'($urandom), BW'($urandom));
         if (k == 5) instr_retire = 1'b1;
         cycle();
      end
      for (int k = 0; k < 6; k++) begin
         set_rsp(DW'($urandom), k == 2); cycle();
      end
      chk("t3_count", 256'(vtx_txn_count), 256'(4));
      chk("t3_ovf", 256'(vtx_overflow), 256'(1));
      chk("t3_addr3", 256'(vtx_mem_addr[127:96]), 256'(32'h20C));
      chk("t3_proto", 256'(vtx_proto_err), 256'(0));

      // 4: accept and response in the same cycle with one outstanding
      set_req(1'b0, 32'h40, 32'h0, 4'h3); cycle();
      set_req(1'b0, 32'h44, 32'h0, 4'hC); set_rsp(32'hAAAA0001, 1'b0); cycle();
      set_rsp(32'hBBBB0002, 1'b0); instr_retire = 1'b1; cycle();
      chk("t4_rdata0", 256'(vtx_mem_rdata[31:0]), 256'(32'hAAAA0001));
      chk("t4_rdata1", 256'(vtx_mem_rdata[63:32]), 256'(32'hBBBB0002));

      // 5: flush with two outstanding, then a fresh one-write instruction
      set_req(1'b0, 32'h300, 32'h0, 4'hF); cycle();
      set_req(1'b0, 32'h304, 32'h0, 4'hF); cycle();
      instr_flush = 1'b1; cycle();
      set_rsp(32'h1, 1'b0); cycle();
      set_rsp(32'h2, 1'b0); cycle();
      set_req(1'b1, 32'h400, 32'h12345678, 4'hF); cycle();
      set_rsp(32'h0, 1'b0); instr_retire = 1'b1; cycle();
      chk("t5_count", 256'(vtx_txn_count), 256'(1));
      chk("t5_wen", 256'(vtx_mem_wen[0]), 256'(1));
      chk("t5_wdata", 256'(vtx_mem_wdata[31:0]), 256'(32'h12345678));
      chk("t5_proto", 256'(vtx_proto_err), 256'(0));

      // 6: stray response, then reset while draining
      set_rsp(32'h5, 1'b0); cycle();
      chk("t6_proto_set", 256'(vtx_proto_err), 256'(1));
      set_req(1'b0, 32'h500, 32'h0, 4'hF); cycle();
      instr_retire = 1'b1; cycle();
      cycle();
      do_reset();
      chk("t6_proto_clr", 256'(vtx_proto_err), 256'(0));
      repeat (3) cycle();

      // random traffic
      for (int c = 0; c < 500; c++) begin
         if (!m_drain && pend.size() < 6 && $urandom_range(0, 2) == 0) begin
            set_req(1'($urandom), AW'($urandom), DW'($urandom), BW'($urandom));
            mem_gnt = ($urandom_range(0, 3) != 0);
         end
         if (pend.size() > 0 && $urandom_range(0, 1) == 1)
            set_rsp(DW'($urandom), $urandom_range(0, 7) == 0);
         if (!m_drain && $urandom_range(0, 5) == 0) instr_retire = 1'b1;
         if ($urandom_range(0, 40) == 0) instr_flush = 1'b1;
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
